// File: rtl/vcpu_pkg.sv
// Shared definitions for the fetch stage: FSM state type, NOP/HALT encodings
// and the location of the opcode field inside an instruction word.
package vcpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
  localparam logic [3:0]  HALT_OPCODE = 4'hF;
  localparam int          OPCODE_MSB  = 31;
  localparam int          OPCODE_LSB  = 28;

  function automatic logic isHaltInstr(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: clears on reset or loadZero, otherwise advances one word
// (4 bytes) when incr is set and holds when it is not.
module pc_reg #(
  parameter int I = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         loadZero,
  input  logic         incr,
  output logic [I-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset || loadZero) begin
      pc <= '0;
    end else if (incr) begin
      pc <= pc + I'(4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: streams words from a one-cycle-latency ROM into
// the datapath, stops on HALT or end of memory, then drains the pipeline.
module fetch_unit
  import vcpu_pkg::*;
#(
  parameter int I            = 32,
  parameter int IMEM_DEPTH   = 256,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         step_en,
  input  logic [I-1:0] imem_rdata,
  output logic [I-1:0] imem_addr,
  output logic [I-1:0] InstrF,
  output logic         busy,
  output logic         done,
  output logic [15:0]  instr_count,
  output fetch_state_t dbgState
);

  localparam int          CW       = $clog2(DRAIN_CYCLES + 1);
  localparam logic [I-1:0] END_ADDR = I'(4 * IMEM_DEPTH);

  fetch_state_t  state, stateNext;
  logic          pending, pendingNext;
  logic [CW-1:0] drainCnt, drainCntNext;
  logic [15:0]   instrCount, instrCountNext;
  logic [I-1:0]  pc;
  logic          pcLoadZero, pcIncr;
  logic          presenting, haltSeen, endOfMem, canFetch;

  // pending acts as the valid flag for imem_rdata: a fetch issued at one edge
  // makes its word valid (and presentable) for exactly the following cycle.
  assign presenting = (state == RUN) && pending;
  assign haltSeen   = presenting && isHaltInstr(imem_rdata[31:0]);
  assign endOfMem   = (state == RUN) && !pending && (pc == END_ADDR);
  assign canFetch   = step_en && (pc < END_ADDR);

  pc_reg #(.I(I)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .loadZero (pcLoadZero),
    .incr     (pcIncr),
    .pc       (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      drainCnt   <= '0;
      instrCount <= '0;
    end else begin
      state      <= stateNext;
      pending    <= pendingNext;
      drainCnt   <= drainCntNext;
      instrCount <= instrCountNext;
    end
  end

  always_comb begin
    stateNext      = state;
    pendingNext    = 1'b0;
    drainCntNext   = drainCnt;
    instrCountNext = instrCount;
    pcLoadZero     = 1'b0;
    pcIncr         = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          stateNext      = RUN;
          pcLoadZero     = 1'b1;
          instrCountNext = '0;
        end
      end
      RUN: begin
        if (presenting && !haltSeen && instrCount != 16'hFFFF) begin
          instrCountNext = instrCount + 16'd1;
        end
        // HALT wins over end-of-memory; both freeze PC and cancel this cycle's fetch.
        if (haltSeen || endOfMem) begin
          stateNext    = DRAIN;
          drainCntNext = CW'(DRAIN_CYCLES);
        end else if (canFetch) begin
          pcIncr      = 1'b1;
          pendingNext = 1'b1;
        end
      end
      DRAIN: begin
        drainCntNext = drainCnt - CW'(1);
        if (drainCnt <= CW'(1)) begin
          stateNext = DONE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    InstrF      = I'(NOP_INSTR);
    if (presenting && !haltSeen) begin
      InstrF = imem_rdata;
    end
    busy        = (state == RUN) || (state == DRAIN);
    done        = (state == DONE);
    imem_addr   = pc;
    instr_count = instrCount;
    dbgState    = state;
  end

endmodule
